traffic_ctrl: RTL
=================

// Module: traffic_ctrl
// PURPOSE
//  Two-way intersection sequencer: produces the 3-bit RGB light codes consumed by the LED PWM driver
//  (light1 = north-south, light2 = east-west; bit2=R, bit1=G, bit0=B).
//  Timing is derived from a 1 Hz tick divided from clk. Adds a pedestrian request that shortens green
//  and a night mode that flashes yellow on both directions.
// PARAMETERS
//  TICK_DIV  125_000_000  clk cycles per tick (1 s at 125 MHz); >=2
//  GREEN_S   20           green duration, ticks; 1..255
//  YELLOW_S  3            yellow duration, ticks; 1..255
//  ALLRED_S  2            all-red clearance, ticks; 1..255
//  PED_S     5            green remaining after pedestrian request, ticks; 1..GREEN_S
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  reset, asynchronous, active-low
//  ped_btn      in   1  pedestrian button, asynchronous level; 2-FF synchronised internally
//  night        in   1  night mode request, asynchronous level; 2-FF synchronised internally
//  light1       out  3  NS light code, registered
//  light2       out  3  EW light code, registered
//  remain       out  8  ticks left in current phase, registered
//  phase        out  3  current state encoding (debug)
//  ped_pending  out  1  pedestrian request latched, not yet served
// BEHAVIOUR
//  Codes: RED=3'b100, GREEN=3'b010, YELLOW=3'b110, OFF=3'b000. Blue never driven.
//  Reset values: state=AR2, remain=ALLRED_S, light1=light2=RED, ped_pending=0, divider=0, blink=0.
//  Divider: counts 0..TICK_DIV-1; tick pulses 1 clk when count==TICK_DIV-1, then wraps to 0.
//  States (phase): NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5, FLASH=6.
//   NS_G: l1=GREEN l2=RED -> NS_Y        NS_Y: l1=YELLOW l2=RED -> AR1   AR1: both RED -> EW_G
//   EW_G: l1=RED l2=GREEN -> EW_Y        EW_Y: l1=RED l2=YELLOW -> AR2   AR2: both RED -> NS_G
//   FLASH: both = blink ? YELLOW : OFF; blink toggles every tick; blink=1 on entry.
//  Timing: on entry remain loads that phase's duration. Each tick decrements remain; tick with
//   remain==1 leaves the state and loads the next duration in the same clk. State occupies exactly
//   D ticks. Lights are registered from next-state: they change in the same edge as state.
//  Pedestrian: rising edge of synchronised ped_btn sets ped_pending. While in NS_G/EW_G with
//   ped_pending=1 and remain>PED_S, remain loads PED_S on the next clk (once; remain<=PED_S untouched).
//   ped_pending clears on entry to AR1 or AR2; an edge in the same clk as that entry wins (stays set).
//  Night: honoured only when leaving AR1 or AR2 (tick, remain==1): night=1 -> FLASH (remain=0,
//   held) instead of the green phase. In FLASH, night=0 at a tick -> AR2 with remain=ALLRED_S
//   (lights both RED). Night never interrupts green/yellow. Pedestrian edges in FLASH are latched.
//  Reset mid-phase: asynchronous return to reset values; no partial phase resumes.
//  remain never wraps below 1 outside FLASH; durations of 0 are illegal parameter values.
// TESTING (TICK_DIV=4, GREEN_S=5, YELLOW_S=2, ALLRED_S=1, PED_S=2)
//  1 Reset release, idle inputs -> both RED 4 clk, NS GREEN 20 clk, NS YELLOW 8, AR 4, EW GREEN 20,
//    EW YELLOW 8, AR 4; 64-clk period repeats; phase sequence 5,0,1,2,3,4,5.
//  2 ped_btn pulse at NS_G with remain=5 -> ped_pending=1, remain=2 within 4 clk, NS YELLOW 2 ticks
//    later; ped_pending=0 on entry to AR1.
//  3 ped_btn pulse at NS_G with remain=1 -> remain unchanged, ped_pending held until AR1 entry.
//  4 night=1 asserted mid EW_G -> EW_G/EW_Y complete normally, AR2 then FLASH: both YELLOW/OFF
//    alternating every 4 clk starting YELLOW; night=0 -> AR2 1 tick then NS_G.
//  5 rst_n low mid NS_Y -> light1=light2=RED, remain=1, phase=5 immediately (no clk edge needed).
//  6 ped_btn held high 3 ticks -> exactly one request latched; no retrigger until released and repressed.

Source files
------------

// File: rtl/traffic_ctrl.sv
// Two-way intersection light sequencer with pedestrian shortening and night flash mode.
// All phase timing is counted in ticks from an internal clock divider.
module traffic_ctrl #(
    parameter int unsigned TICK_DIV = 125_000_000,
    parameter int unsigned GREEN_S  = 20,
    parameter int unsigned YELLOW_S = 3,
    parameter int unsigned ALLRED_S = 2,
    parameter int unsigned PED_S    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_btn,
    input  logic       night,
    output logic [2:0] light1,
    output logic [2:0] light2,
    output logic [7:0] remain,
    output logic [2:0] phase,
    output logic       ped_pending
);

    localparam int unsigned DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    localparam logic [7:0] GREEN_D  = 8'(GREEN_S);
    localparam logic [7:0] YELLOW_D = 8'(YELLOW_S);
    localparam logic [7:0] ALLRED_D = 8'(ALLRED_S);
    localparam logic [7:0] PED_D    = 8'(PED_S);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] OFF    = 3'b000;

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR1   = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR2   = 3'd5,
        FLASH = 3'd6
    } state_t;

    state_t           state, next_state;
    logic [7:0]       next_remain;
    logic             blink, next_blink;
    logic             next_pending;
    logic [2:0]       next_light1, next_light2;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       ped_sync;
    logic [1:0]       night_sync;
    logic             ped_prev;
    logic             ped_edge;
    logic             night_s;
    logic             entering_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_sync   <= '0;
            night_sync <= '0;
            ped_prev   <= 1'b0;
        end else begin
            ped_sync   <= {ped_sync[0], ped_btn};
            night_sync <= {night_sync[0], night};
            ped_prev   <= ped_sync[1];
        end
    end

    assign ped_edge = ped_sync[1] & ~ped_prev;
    assign night_s  = night_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_comb begin
        next_state  = state;
        next_remain = remain;
        next_blink  = blink;
        if (tick) begin
            if (state == FLASH) begin
                if (!night_s) begin
                    next_state  = AR2;
                    next_remain = ALLRED_D;
                end else begin
                    next_blink = ~blink;
                end
            end else if (remain == 8'd1) begin
                case (state)
                    NS_G: begin next_state = NS_Y; next_remain = YELLOW_D; end
                    NS_Y: begin next_state = AR1;  next_remain = ALLRED_D; end
                    EW_G: begin next_state = EW_Y; next_remain = YELLOW_D; end
                    EW_Y: begin next_state = AR2;  next_remain = ALLRED_D; end
                    AR1, AR2: begin
                        if (night_s) begin
                            next_state  = FLASH;
                            next_remain = 8'd0;
                            next_blink  = 1'b1;
                        end else begin
                            next_state  = (state == AR1) ? EW_G : NS_G;
                            next_remain = GREEN_D;
                        end
                    end
                    default: begin next_state = AR2; next_remain = ALLRED_D; end
                endcase
            end else begin
                next_remain = remain - 8'd1;
            end
        end
        // Shortening can never coincide with a phase exit since remain > PED_S >= 1.
        if ((state == NS_G || state == EW_G) && ped_pending && remain > PED_D) begin
            next_remain = PED_D;
        end
    end

    assign entering_clear = (next_state != state) && (next_state == AR1 || next_state == AR2);

    always_comb begin
        next_pending = ped_pending;
        if (ped_edge) begin
            next_pending = 1'b1;
        end else if (entering_clear) begin
            next_pending = 1'b0;
        end
    end

    always_comb begin
        next_light1 = RED;
        next_light2 = RED;
        case (next_state)
            NS_G:    next_light1 = GREEN;
            NS_Y:    next_light1 = YELLOW;
            EW_G:    next_light2 = GREEN;
            EW_Y:    next_light2 = YELLOW;
            FLASH: begin
                next_light1 = next_blink ? YELLOW : OFF;
                next_light2 = next_blink ? YELLOW : OFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= AR2;
            remain      <= ALLRED_D;
            blink       <= 1'b0;
            ped_pending <= 1'b0;
            light1      <= RED;
            light2      <= RED;
        end else begin
            state       <= next_state;
            remain      <= next_remain;
            blink       <= next_blink;
            ped_pending <= next_pending;
            light1      <= next_light1;
            light2      <= next_light2;
        end
    end

    assign phase = state;

endmodule
